// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and status bundle between fetch-PC sequencer and pipeline
interface pc_sequencer_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_target;
    logic             trap_valid;
    logic             halt;
    logic             resume;
    logic [XLEN-1:0]  pc_out;
    logic             pc_valid;
    logic             misaligned_err;
    logic [CNT_W-1:0] fetch_count;

    // pipeline / hazard side: issues control, observes the fetch stream
    modport master (
        output stall, redirect_valid, redirect_target, trap_valid, halt, resume,
        input  pc_out, pc_valid, misaligned_err, fetch_count
    );

    // sequencer side
    modport slave (
        input  stall, redirect_valid, redirect_target, trap_valid, halt, resume,
        output pc_out, pc_valid, misaligned_err, fetch_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with trap/redirect/stall/halt arbitration (optional PC_BOUND_WRAP_EN)
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(64'h0),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(64'h100),
    parameter int              STEP         = 4,
    parameter int              CNT_W        = 32,
    parameter logic [XLEN-1:0] PC_LIMIT     = XLEN'(64'h40)
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);
    // STEP is a power of two, so the low log2(STEP) bits are exactly STEP-1
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    state_t           state;
    logic [XLEN-1:0]  pc;
    logic             valid;
    logic             err;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  seq_pc_raw;
    logic [XLEN-1:0]  seq_pc;
    logic             target_misaligned;

    assign seq_pc_raw        = pc + STEP_INC;
    assign target_misaligned = (bus.redirect_target & ALIGN_MASK) != '0;

`ifdef PC_BOUND_WRAP_EN
    // bounded test programs loop back to the reset vector instead of running off the end
    assign seq_pc = (seq_pc_raw >= PC_LIMIT) ? RESET_VECTOR : seq_pc_raw;
`else
    assign seq_pc = seq_pc_raw;
    logic unused_pc_limit;
    assign unused_pc_limit = ^PC_LIMIT;
`endif

    assign bus.pc_out         = pc;
    assign bus.pc_valid       = valid;
    assign bus.misaligned_err = err;
    assign bus.fetch_count    = count;

    // sequencer FSM: all outputs registered, flushes (trap/redirect) beat halt and stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc    <= RESET_VECTOR;
            valid <= 1'b0;
            err   <= 1'b0;
            count <= '0;
        end else begin
            err <= 1'b0;
            if (valid && !bus.stall) begin
                count <= count + CNT_W'(1);
            end
            case (state)
                // first edge out of reset: publish RESET_VECTOR without advancing it
                BOOT: begin
                    valid <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (bus.trap_valid) begin
                        pc <= TRAP_VECTOR;
                    end else if (bus.redirect_valid) begin
                        if (target_misaligned) begin
                            pc  <= TRAP_VECTOR;
                            err <= 1'b1;
                        end else begin
                            pc <= bus.redirect_target;
                        end
                    end else if (bus.halt) begin
                        state <= HALT;
                        valid <= 1'b0;
                    end else if (!bus.stall) begin
                        pc <= seq_pc;
                    end
                end
                HALT: begin
                    if (bus.trap_valid) begin
                        state <= RUN;
                        pc    <= TRAP_VECTOR;
                        valid <= 1'b1;
                    end else if (bus.resume) begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the pipelined RISC-V fetch stage.
- Generalises the single-cycle PC register. Adds configurable width, reset vector and step size.
- Arbitrates trap, branch redirect, stall and halt, and flags misaligned targets.
- Counts issued fetches for the pipeline performance/debug path.

Parameters:
XLEN, 64, PC width in bits
RESET_VECTOR, 64'h0, PC value loaded on reset and on boot
TRAP_VECTOR, 64'h100, PC value loaded on trap_valid
STEP, 4, byte increment per sequential fetch; must be a power of two
CNT_W, 32, width of fetch counter
PC_LIMIT, 64'h40, upper bound used only by the optional feature

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hold PC; hazard unit request
redirect_valid  input  1  branch/jump taken in EX
redirect_target  input  XLEN  branch/jump target address
trap_valid  input  1  exception/trap request
halt  input  1  enter HALT state
resume  input  1  leave HALT state
pc_out  output  XLEN  current fetch address (registered)
pc_valid  output  1  pc_out is a valid fetch this cycle
misaligned_err  output  1  one-cycle pulse: redirect_target not STEP-aligned
fetch_count  output  CNT_W  number of valid fetches issued since reset

Behaviour:
- Reset (reset_n low, asynchronous):
  - pc_out=RESET_VECTOR, pc_valid=0, misaligned_err=0, fetch_count=0, state=BOOT.
  - Outputs hold while reset_n is low. Reset asserted mid-operation aborts everything immediately.
- State BOOT (first rising edge after reset_n deasserts):
  - pc_out stays RESET_VECTOR; pc_valid=1 on the next cycle; state->RUN.
  - Guarantees RESET_VECTOR is fetched exactly once after reset and is never skipped.
- State RUN, per-cycle priority:
  1. trap_valid: pc_out<=TRAP_VECTOR.
  2. redirect_valid with an aligned target: pc_out<=redirect_target.
  3. redirect_valid with a misaligned target (target mod STEP != 0):
     - pc_out<=TRAP_VECTOR.
     - misaligned_err=1 for exactly one cycle.
  4. halt: state->HALT, pc_out held, pc_valid<=0.
  5. stall: pc_out held, pc_valid stays 1, fetch_count not incremented.
  6. Otherwise pc_out<=pc_out+STEP.
- Trap and redirect override stall: a flush beats a hold.
- Halt is ignored in a cycle that also carries trap or redirect; it takes effect the next cycle if still asserted.
- State HALT:
  - pc_out held, pc_valid=0.
  - resume -> RUN with pc_out unchanged; pc_valid=1 on the following cycle.
  - trap_valid in HALT -> RUN with pc_out<=TRAP_VECTOR.
  - redirect_valid in HALT is ignored.
- fetch_count:
  - Increments on each rising edge where pc_valid=1 and stall=0.
  - Wraps modulo 2^CNT_W silently.
- Arithmetic:
  - pc_out+STEP wraps modulo 2^XLEN; no error is raised on wrap.
  - The alignment check uses only the low log2(STEP) bits.
- Latency: redirect/trap sampled at edge N appears on pc_out after edge N (one cycle).
- No combinational path from any input to pc_out or pc_valid.

Optional Feature:
- Macro PC_BOUND_WRAP_EN.
- Defined:
  - In RUN, if the sequential next PC (pc_out+STEP) >= PC_LIMIT, pc_out<=RESET_VECTOR instead.
  - Applies to sequential increments only. Redirect and trap targets are not bounded.
  - Intended for bounded test programs (e.g. the sort benchmark) to loop.
- Undefined: no bound check; PC_LIMIT unused; increments wrap only at 2^XLEN.

Test Plan:
- Reset and boot: hold reset_n=0 for 3 cycles, release.
  - pc_out=0x0 with pc_valid=0 during reset.
  - pc_out=0x0 with pc_valid=1 for one cycle, then 0x4, 0x8.
  - fetch_count=3 after three valid fetches.
- Stall vs redirect: at pc_out=0x10, assert stall 2 cycles.
  - pc_out holds 0x10 and fetch_count is frozen.
  - Then stall=1 together with redirect_valid=1, target=0x80: pc_out=0x80 next cycle.
- Misaligned redirect: redirect_target=0x22 with STEP=4.
  - pc_out=0x100 (TRAP_VECTOR) and misaligned_err=1 for exactly one cycle.
- Trap priority: trap_valid=1 and redirect_valid=1 (0x40) in the same cycle.
  - pc_out=0x100.
- Halt/resume: assert halt at pc_out=0x20.
  - pc_valid=0 and pc_out=0x20 held for 5 cycles.
  - resume: pc_valid=1, then pc_out=0x24.
- Async reset mid-run plus optional wrap:
  - Drop reset_n between edges at pc_out=0x3C: pc_out=0x0 immediately, without waiting for a clock edge.
  - With PC_BOUND_WRAP_EN and PC_LIMIT=0x40: sequential run from 0x38 gives 0x3C then 0x0.
